// File: rtl/fb_arbiter_if.sv
// Frame-memory arbiter bus: display fetch port, ant RMW port and the memory command port.
// slave = arbiter view, master = requesters/memory view.
interface fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              ant_req;
    logic              ant_we;
    logic              ant_lock;
    logic [ADDR_W-1:0] ant_addr;
    logic [DATA_W-1:0] ant_wdata;
    logic              ant_gnt;
    logic              ant_rvalid;
    logic [DATA_W-1:0] ant_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, ant_req, ant_we, ant_lock, ant_addr, ant_wdata, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata, ant_gnt, ant_rvalid, ant_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, ant_req, ant_we, ant_lock, ant_addr, ant_wdata, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata, ant_gnt, ant_rvalid, ant_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port frame memory arbiter: display has priority, ant gets a starvation guard
// and an atomic read-modify-write lock. Read data returns two cycles after acceptance.
module fb_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_arbiter_if.slave bus,
    output logic        ant_starved
);
    typedef enum logic {FREE, ANT_LOCK} state_t;

    localparam logic [7:0] WMAX = 8'(WAIT_MAX);

    state_t            state, state_nxt;
    logic [7:0]        wait_cnt, wait_nxt;
    logic              disp_gnt, ant_gnt;
    logic [1:0]        disp_tag, ant_tag;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, disp_rdata_q, ant_rdata_q;
    logic              disp_rvalid_q, ant_rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FREE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE:     if (ant_gnt && bus.ant_lock) state_nxt = ANT_LOCK;
            ANT_LOCK: if (!bus.ant_req || (ant_gnt && !bus.ant_lock)) state_nxt = FREE;
            default:  state_nxt = FREE;
        endcase
    end

    // Dropping ant_req while locked releases the memory in the same cycle, so display may go.
    always_comb begin
        disp_gnt = 1'b0;
        ant_gnt  = 1'b0;
        if (rst_n) begin
            case (state)
                FREE: begin
                    if (bus.ant_req && wait_cnt == WMAX) ant_gnt  = 1'b1;
                    else if (bus.disp_req)               disp_gnt = 1'b1;
                    else if (bus.ant_req)                ant_gnt  = 1'b1;
                end
                ANT_LOCK: begin
                    ant_gnt  = bus.ant_req;
                    disp_gnt = !bus.ant_req && bus.disp_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (!bus.ant_req || ant_gnt) wait_nxt = 8'd0;
        else if (wait_cnt == WMAX)   wait_nxt = WMAX;
        else                         wait_nxt = wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= 8'd0;
            ant_starved   <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            disp_tag      <= 2'b00;
            ant_tag       <= 2'b00;
            disp_rvalid_q <= 1'b0;
            ant_rvalid_q  <= 1'b0;
            disp_rdata_q  <= '0;
            ant_rdata_q   <= '0;
        end else begin
            wait_cnt    <= wait_nxt;
            ant_starved <= (wait_nxt == WMAX);
            if (disp_gnt) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.disp_addr;
                mem_wdata_q <= '0;
            end else if (ant_gnt) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.ant_we;
                mem_addr_q  <= bus.ant_addr;
                mem_wdata_q <= bus.ant_wdata;
            end else begin
                mem_en_q <= 1'b0;
                mem_we_q <= 1'b0;
            end
            // tag[0]: command issued, tag[1]: memory sampled, data lands on the next edge
            disp_tag      <= {disp_tag[0], disp_gnt};
            ant_tag       <= {ant_tag[0], ant_gnt && !bus.ant_we};
            disp_rvalid_q <= disp_tag[1];
            ant_rvalid_q  <= ant_tag[1];
            if (disp_tag[1]) disp_rdata_q <= bus.mem_rdata;
            if (ant_tag[1])  ant_rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.disp_gnt    = disp_gnt;
    assign bus.ant_gnt     = ant_gnt;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.ant_rvalid  = ant_rvalid_q;
    assign bus.ant_rdata   = ant_rdata_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus a random phase, all scored every cycle
// against a transaction-level model of grants, memory commands and read returns.
module tb_fb_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int WM = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ant_starved;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ant_starved(ant_starved)
    );

    // Frame memory: 1-cycle read latency, driven by the DUT's registered command.
    logic [DW-1:0] fmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) fmem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= fmem[bus.mem_addr];
        end
    end

    // Reference model state
    typedef struct {int due; bit disp; logic [DW-1:0] data;} rd_t;
    rd_t           pend[$];
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    bit            locked;
    int            wcnt, cyc;
    logic          e_en, e_we, e_drv, e_arv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_drd, e_ard;
    logic          obs_dg, obs_ag;
    int            n_chk = 0, n_fail = 0;

    task automatic mdl_reset();
        locked = 0; wcnt = 0; pend.delete();
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_drv = 0; e_arv = 0; e_drd = '0; e_ard = '0;
    endtask

    // One clock: score the cycle at the falling edge, advance the model, step past the edge.
    task automatic tick();
        logic eg_d, eg_a;
        rd_t r;
        @(negedge clk);
        if (!rst_n) mdl_reset();
        eg_d = 0; eg_a = 0;
        if (rst_n) begin
            if (locked) begin
                if (bus.ant_req) eg_a = 1; else eg_d = bus.disp_req;
            end else if (bus.ant_req && wcnt == WM) eg_a = 1;
            else if (bus.disp_req) eg_d = 1;
            else if (bus.ant_req)  eg_a = 1;
        end
        obs_dg = bus.disp_gnt; obs_ag = bus.ant_gnt;
        n_chk += 11;
        if (bus.disp_gnt !== eg_d) begin n_fail++; $display("FAIL disp_gnt cyc %0d: got %b want %b", cyc, bus.disp_gnt, eg_d); end
        if (bus.ant_gnt !== eg_a) begin n_fail++; $display("FAIL ant_gnt cyc %0d: got %b want %b", cyc, bus.ant_gnt, eg_a); end
        if (bus.mem_en !== e_en) begin n_fail++; $display("FAIL mem_en cyc %0d: got %b want %b", cyc, bus.mem_en, e_en); end
        if (bus.mem_we !== e_we) begin n_fail++; $display("FAIL mem_we cyc %0d: got %b want %b", cyc, bus.mem_we, e_we); end
        if (bus.mem_addr !== e_addr) begin n_fail++; $display("FAIL mem_addr cyc %0d: got %h want %h", cyc, bus.mem_addr, e_addr); end
        if (bus.mem_wdata !== e_wdata) begin n_fail++; $display("FAIL mem_wdata cyc %0d: got %h want %h", cyc, bus.mem_wdata, e_wdata); end
        if (bus.disp_rvalid !== e_drv) begin n_fail++; $display("FAIL disp_rvalid cyc %0d: got %b want %b", cyc, bus.disp_rvalid, e_drv); end
        if (bus.ant_rvalid !== e_arv) begin n_fail++; $display("FAIL ant_rvalid cyc %0d: got %b want %b", cyc, bus.ant_rvalid, e_arv); end
        if (bus.disp_rdata !== e_drd) begin n_fail++; $display("FAIL disp_rdata cyc %0d: got %h want %h", cyc, bus.disp_rdata, e_drd); end
        if (bus.ant_rdata !== e_ard) begin n_fail++; $display("FAIL ant_rdata cyc %0d: got %h want %h", cyc, bus.ant_rdata, e_ard); end
        if (ant_starved !== (wcnt == WM)) begin n_fail++; $display("FAIL ant_starved cyc %0d: got %b want %b", cyc, ant_starved, wcnt == WM); end
        if (rst_n) begin
            e_drv = 0; e_arv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (r.disp) begin e_drv = 1; e_drd = r.data; end
                else        begin e_arv = 1; e_ard = r.data; end
            end
            if (eg_d) begin
                e_en = 1; e_we = 0; e_addr = bus.disp_addr; e_wdata = '0;
                pend.push_back('{cyc + 2, 1'b1, mdl_mem[bus.disp_addr]});
            end else if (eg_a) begin
                e_en = 1; e_we = bus.ant_we; e_addr = bus.ant_addr; e_wdata = bus.ant_wdata;
                if (bus.ant_we) mdl_mem[bus.ant_addr] = bus.ant_wdata;
                else pend.push_back('{cyc + 2, 1'b0, mdl_mem[bus.ant_addr]});
            end else begin
                e_en = 0; e_we = 0;
            end
            if (eg_a) locked = bus.ant_lock;
            else if (!bus.ant_req) locked = 0;
            if (!bus.ant_req || eg_a) wcnt = 0;
            else if (wcnt < WM) wcnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.ant_req = 0; bus.ant_we = 0; bus.ant_lock = 0; bus.ant_addr = '0; bus.ant_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        n_chk++;
        if (bus.mem_en !== 0 || bus.mem_addr !== '0 || bus.disp_rvalid !== 0 || ant_starved !== 0) begin
            n_fail++; $display("FAIL reset_state: en=%b addr=%h drv=%b starved=%b want all 0", bus.mem_en, bus.mem_addr, bus.disp_rvalid, ant_starved);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_display_alone();
        for (int i = 0; i < 3; i++) begin
            bus.disp_req = 1; bus.disp_addr = AW'(16 + i);
            tick();
            n_chk += 2;
            if (obs_dg !== 1) begin n_fail++; $display("FAIL disp_alone_gnt %0d: got %b want 1", i, obs_dg); end
            if (bus.mem_addr !== AW'(16 + i)) begin n_fail++; $display("FAIL disp_alone_addr %0d: got %h want %h", i, bus.mem_addr, 16 + i); end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_contention();
        int ants = 0, disps = 0;
        bus.disp_req = 1; bus.ant_req = 1; bus.ant_we = 0; bus.ant_lock = 0;
        bus.disp_addr = AW'($urandom); bus.ant_addr = AW'($urandom);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_ag) begin ants++; bus.ant_addr = AW'($urandom); end
            if (obs_dg) begin disps++; bus.disp_addr = AW'($urandom); end
        end
        n_chk++;
        if (ants != 4 || disps != 16) begin n_fail++; $display("FAIL contention_ratio: ant %0d disp %0d want 4/16", ants, disps); end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_rmw_lock();
        int n = 0;
        bus.disp_req = 1; bus.disp_addr = AW'($urandom);
        bus.ant_req = 1; bus.ant_we = 0; bus.ant_lock = 1; bus.ant_addr = AW'('h1234);
        do begin
            tick(); n++;
            if (obs_dg) bus.disp_addr = AW'($urandom);
        end while (!obs_ag && n < 20);
        n_chk++;
        if (!obs_ag) begin n_fail++; $display("FAIL rmw_read_gnt: no ant grant within %0d cycles", n); end
        bus.ant_we = 1; bus.ant_lock = 0; bus.ant_wdata = 8'h5A;
        tick();
        n_chk += 2;
        if (obs_ag !== 1 || obs_dg !== 0) begin n_fail++; $display("FAIL rmw_write_gnt: ant %b disp %b want 1/0", obs_ag, obs_dg); end
        bus.ant_req = 0; bus.ant_we = 0;
        tick();
        if (obs_dg !== 1) begin n_fail++; $display("FAIL rmw_disp_after: got %b want 1", obs_dg); end
        idle_inputs();
        repeat (3) tick();
        n_chk++;
        if (fmem[AW'('h1234)] !== 8'h5A) begin n_fail++; $display("FAIL rmw_mem: got %h want 5a", fmem[AW'('h1234)]); end
    endtask

    task automatic test_lock_abandon();
        bus.ant_req = 1; bus.ant_we = 0; bus.ant_lock = 1; bus.ant_addr = AW'($urandom);
        tick();
        bus.ant_req = 0; bus.disp_req = 1; bus.disp_addr = AW'($urandom);
        tick();
        n_chk++;
        if (obs_dg !== 1) begin n_fail++; $display("FAIL lock_abandon: disp_gnt got %b want 1", obs_dg); end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_read();
        bus.disp_req = 1; bus.disp_addr = AW'($urandom);
        tick();
        bus.disp_req = 0;
        rst_n = 0;
        #1;
        n_chk++;
        if (bus.mem_en !== 0 || bus.disp_rvalid !== 0) begin
            n_fail++; $display("FAIL reset_mid_read: mem_en %b disp_rvalid %b want 0/0", bus.mem_en, bus.disp_rvalid);
        end
        repeat (2) tick();
        rst_n = 1;
        repeat (5) tick();
    endtask

    task automatic test_idle();
        idle_inputs();
        repeat (20) tick();
        n_chk++;
        if (bus.mem_en !== 0 || ant_starved !== 0) begin n_fail++; $display("FAIL idle: mem_en %b starved %b want 0/0", bus.mem_en, ant_starved); end
    endtask

    task automatic test_random();
        bit dp = 0, ap = 0;
        for (int i = 0; i < 400; i++) begin
            if (!dp) begin
                dp = ($urandom_range(0, 2) != 0);
                bus.disp_req = dp; bus.disp_addr = AW'($urandom_range(0, 15));
            end
            if (!ap) begin
                ap = ($urandom_range(0, 1) != 0);
                bus.ant_req = ap; bus.ant_we = 1'($urandom); bus.ant_lock = 1'($urandom);
                bus.ant_addr = AW'($urandom_range(0, 15)); bus.ant_wdata = DW'($urandom);
            end
            tick();
            if (obs_dg) dp = 0;
            if (obs_ag) ap = 0;
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom); fmem[i] = v; mdl_mem[i] = v;
        end
        bus.mem_rdata = '0;
        idle_inputs();
        mdl_reset();
        cyc = 0;
        rst_n = 0;
        @(posedge clk); #1;
        test_reset();
        test_display_alone();
        test_contention();
        test_rmw_lock();
        test_lock_abandon();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
